// File: rtl/md_iter_unit.sv
// Iterative radix-2 multiply/divide unit for EXE: one operand bit per cycle, W cycles per
// operation, HI/LO results with sign correction, flush abort and divide-by-zero flag.
//
// state | meaning
// IDLE  | waiting for start; results held
// RUN   | iterating, cnt = number of steps already taken
module md_iter_unit #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         flush,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         div_zero
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } stateT;

    localparam logic [W-1:0] CNT_LAST = W'(W - 1);

    stateT          state;
    stateT          stateNext;
    logic [W-1:0]   cnt;
    logic [W-1:0]   opnd;
    logic [W-1:0]   rem;
    logic [W-1:0]   aSamp;
    logic [2*W-1:0] acc;
    logic           isDiv;
    logic           aNeg;
    logic           sgnDiff;
    logic           bZero;

    logic           accept;
    logic           step;
    logic           finish;
    logic           lastIter;

    logic           opSigned;
    logic [W-1:0]   aMag;
    logic [W-1:0]   bMag;

    logic [W:0]     sumHi;
    logic [W:0]     shifted;
    logic [W:0]     trial;
    logic [2*W-1:0] mulNext;
    logic [W-1:0]   remNext;
    logic [W-1:0]   quoNext;

    logic [2*W-1:0] prodRes;
    logic [W-1:0]   hiRes;
    logic [W-1:0]   loRes;

    assign opSigned = ~op[0];
    assign aMag     = (opSigned && a[W-1]) ? (~a + 1'b1) : a;
    assign bMag     = (opSigned && b[W-1]) ? (~b + 1'b1) : b;
    assign lastIter = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    accept    = 1'b1;
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    stateNext = IDLE;
                end else begin
                    step = 1'b1;
                    if (lastIter) begin
                        finish    = 1'b1;
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Multiply keeps the multiplier in acc[W-1:0] and shifts the product in from the top;
    // divide shifts the dividend out of acc[W-1:0] while quotient bits enter at the bottom.
    always_comb begin
        sumHi   = {1'b0, acc[2*W-1:W]} + {1'b0, opnd};
        mulNext = acc[0] ? {sumHi, acc[W-1:1]} : {1'b0, acc[2*W-1:1]};
        shifted = {rem, acc[W-1]};
        trial   = shifted - {1'b0, opnd};
        if (trial[W]) begin
            remNext = shifted[W-1:0];
            quoNext = {acc[W-2:0], 1'b0};
        end else begin
            remNext = trial[W-1:0];
            quoNext = {acc[W-2:0], 1'b1};
        end
    end

    always_comb begin
        prodRes = sgnDiff ? (~mulNext + 1'b1) : mulNext;
        hiRes   = prodRes[2*W-1:W];
        loRes   = prodRes[W-1:0];
        if (isDiv) begin
            if (bZero) begin
                hiRes = aSamp;
                loRes = '1;
            end else begin
                loRes = sgnDiff ? (~quoNext + 1'b1) : quoNext;
                hiRes = aNeg ? (~remNext + 1'b1) : remNext;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
            cnt      <= '0;
            opnd     <= '0;
            rem      <= '0;
            aSamp    <= '0;
            acc      <= '0;
            isDiv    <= 1'b0;
            aNeg     <= 1'b0;
            sgnDiff  <= 1'b0;
            bZero    <= 1'b0;
        end else begin
            busy <= (stateNext == RUN);
            done <= finish;
            if (accept) begin
                isDiv   <= op[1];
                aNeg    <= opSigned & a[W-1];
                sgnDiff <= opSigned & (a[W-1] ^ b[W-1]);
                bZero   <= (b == '0);
                aSamp   <= a;
                opnd    <= op[1] ? bMag : aMag;
                acc     <= {{W{1'b0}}, (op[1] ? aMag : bMag)};
                rem     <= '0;
                cnt     <= '0;
            end else if (step) begin
                cnt <= cnt + 1'b1;
                if (isDiv) begin
                    acc[W-1:0] <= quoNext;
                    rem        <= remNext;
                end else begin
                    acc <= mulNext;
                end
            end
            if (finish) begin
                hi       <= hiRes;
                lo       <= loRes;
                div_zero <= isDiv & bZero;
            end
        end
    end

endmodule

// File: tb/tb_md_iter_unit.sv
// Bench for md_iter_unit: W=32 and W=8 instances, directed vector table, hand-written
// flush/reset/back-to-back sequences, and random operations against an arithmetic model.
module tb_md_iter_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clrn;
    logic        start32, flush32, busy32, done32, dz32;
    logic [1:0]  op32;
    logic [31:0] a32, b32, hi32, lo32;
    logic        start8, flush8, busy8, done8, dz8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, hi8, lo8;

    int nTests = 0;
    int nFail  = 0;

    md_iter_unit #(.W(32)) dut32 (
        .clk(clk), .clrn(clrn), .start(start32), .op(op32), .a(a32), .b(b32),
        .flush(flush32), .busy(busy32), .done(done32), .hi(hi32), .lo(lo32), .div_zero(dz32)
    );

    md_iter_unit #(.W(8)) dut8 (
        .clk(clk), .clrn(clrn), .start(start8), .op(op8), .a(a8), .b(b8),
        .flush(flush8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_zero(dz8)
    );

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eHi;
        logic [31:0] eLo;
        logic        eDz;
    } vecT;

    vecT vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic on 64-bit values, truncated to n bits.
    function automatic void refModel(input int n, input logic [1:0] o, input logic [63:0] x,
                                     input logic [63:0] y, output logic [63:0] rh,
                                     output logic [63:0] rl, output logic rdz);
        logic [63:0] mask;
        logic [63:0] ux, uy, p;
        longint      sx, sy, q, r;
        mask = (64'd1 << n) - 64'd1;
        ux   = x & mask;
        uy   = y & mask;
        sx   = ux[n-1] ? $signed(ux) - $signed(64'd1 << n) : $signed(ux);
        sy   = uy[n-1] ? $signed(uy) - $signed(64'd1 << n) : $signed(uy);
        rdz  = 1'b0;
        if (o[1]) begin
            if (uy == 64'd0) begin
                rh  = ux;
                rl  = mask;
                rdz = 1'b1;
            end else if (o[0]) begin
                rh = (ux % uy) & mask;
                rl = (ux / uy) & mask;
            end else begin
                q  = sx / sy;
                r  = sx % sy;
                rh = 64'(r) & mask;
                rl = 64'(q) & mask;
            end
        end else begin
            if (o[0]) p = ux * uy;
            else      p = 64'(sx * sy);
            rh = (p >> n) & mask;
            rl = p & mask;
        end
    endfunction

    task automatic doOp32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] rh, output logic [31:0] rl, output logic rdz,
                          output int lat, output int bc);
        @(negedge clk);
        start32 = 1'b1; op32 = o; a32 = x; b32 = y;
        @(posedge clk); #1;
        start32 = 1'b0;
        lat = -1;
        bc  = busy32 ? 1 : 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (busy32) bc++;
            if (done32) begin
                lat = k;
                break;
            end
        end
        rh = hi32; rl = lo32; rdz = dz32;
    endtask

    task automatic doOp8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                         output logic [7:0] rh, output logic [7:0] rl, output logic rdz,
                         output int lat);
        @(negedge clk);
        start8 = 1'b1; op8 = o; a8 = x; b8 = y;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            if (done8) begin
                lat = k;
                break;
            end
        end
        rh = hi8; rl = lo8; rdz = dz8;
    endtask

    initial begin
        logic [31:0] rh, rl;
        logic [7:0]  rh8, rl8;
        logic        rdz, sawDone;
        logic [63:0] eh, el;
        logic        edz;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        int          lat, bc, k;

        vecs[0] = '{"mult -3*5",      2'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vecs[1] = '{"divu 100/7",     2'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0};
        vecs[2] = '{"div -7/2",       2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3] = '{"div 7/-2",       2'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[4] = '{"div min/-1",     2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[5] = '{"multu 6*7",      2'd1, 32'd6,        32'd7,        32'h00000000, 32'h0000002A, 1'b0};
        vecs[6] = '{"mult min*min",   2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[7] = '{"multu max*max",  2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[8] = '{"div neg/0",      2'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        vecs[9] = '{"divu x/0",       2'd3, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, 1'b1};

        clrn = 1'b0;
        start32 = 1'b0; flush32 = 1'b0; op32 = 2'd0; a32 = '0; b32 = '0;
        start8  = 1'b0; flush8  = 1'b0; op8  = 2'd0; a8  = '0; b8  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy32", 64'(busy32), 64'd0);
        chk("reset done32", 64'(done32), 64'd0);
        chk("reset hi32",   64'(hi32),   64'd0);
        chk("reset lo32",   64'(lo32),   64'd0);
        chk("reset dz32",   64'(dz32),   64'd0);
        chk("reset busy8",  64'(busy8),  64'd0);
        @(negedge clk);
        clrn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            doOp32(vecs[i].op, vecs[i].a, vecs[i].b, rh, rl, rdz, lat, bc);
            chk({vecs[i].name, " latency"}, 64'(lat), 64'd32);
            chk({vecs[i].name, " busy cycles"}, 64'(bc), 64'd32);
            chk({vecs[i].name, " hi"}, 64'(rh), 64'(vecs[i].eHi));
            chk({vecs[i].name, " lo"}, 64'(rl), 64'(vecs[i].eLo));
            chk({vecs[i].name, " div_zero"}, 64'(rdz), 64'(vecs[i].eDz));
        end

        // Flush at E10 of MULTU 6*7: abort, no done, results held from the last divide-by-zero.
        @(negedge clk);
        start32 = 1'b1; op32 = 2'd1; a32 = 32'd6; b32 = 32'd7;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush32 = 1'b1;
        @(posedge clk); #1;
        flush32 = 1'b0;
        chk("flush E10 busy", 64'(busy32), 64'd0);
        sawDone = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done32) sawDone = 1'b1;
        end
        chk("flush E10 no done", 64'(sawDone), 64'd0);
        chk("flush E10 hi held", 64'(hi32), 64'(vecs[9].eHi));
        chk("flush E10 lo held", 64'(lo32), 64'(vecs[9].eLo));
        chk("flush E10 dz held", 64'(dz32), 64'd1);

        // Flush on the final iteration edge suppresses done.
        @(negedge clk);
        start32 = 1'b1; op32 = 2'd0; a32 = 32'd9; b32 = 32'd9;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (31) @(posedge clk);
        #1 flush32 = 1'b1;
        @(posedge clk); #1;
        flush32 = 1'b0;
        chk("flush EW done", 64'(done32), 64'd0);
        chk("flush EW busy", 64'(busy32), 64'd0);
        chk("flush EW lo held", 64'(lo32), 64'(vecs[9].eLo));

        // flush and start together in IDLE: start loses.
        @(negedge clk);
        start32 = 1'b1; flush32 = 1'b1; op32 = 2'd1; a32 = 32'd2; b32 = 32'd3;
        @(posedge clk); #1;
        start32 = 1'b0; flush32 = 1'b0;
        chk("idle flush+start busy", 64'(busy32), 64'd0);

        // start pulse during RUN with different operands is ignored.
        @(negedge clk);
        start32 = 1'b1; op32 = 2'd1; a32 = 32'd6; b32 = 32'd7;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start32 = 1'b1; op32 = 2'd3; a32 = 32'd100; b32 = 32'd7;
        @(posedge clk); #1;
        start32 = 1'b0; a32 = '0; b32 = '0;
        chk("ignored start busy", 64'(busy32), 64'd1);
        lat = -1;
        for (k = 6; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done32) begin
                lat = k;
                break;
            end
        end
        chk("ignored start latency", 64'(lat), 64'd32);
        chk("ignored start hi", 64'(hi32), 64'd0);
        chk("ignored start lo", 64'(lo32), 64'h2A);

        // W=8: MULTU FF*FF, then a second start held in the done cycle.
        @(negedge clk);
        start8 = 1'b1; op8 = 2'd1; a8 = 8'hFF; b8 = 8'hFF;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = -1;
        for (k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            if (done8) begin
                lat = k;
                break;
            end
        end
        chk("w8 ff*ff latency", 64'(lat), 64'd8);
        chk("w8 ff*ff hi", 64'(hi8), 64'hFE);
        chk("w8 ff*ff lo", 64'(lo8), 64'h01);
        start8 = 1'b1; op8 = 2'd1; a8 = 8'd3; b8 = 8'd5;
        @(posedge clk); #1;
        start8 = 1'b0;
        chk("w8 b2b busy", 64'(busy8), 64'd1);
        chk("w8 b2b done fell", 64'(done8), 64'd0);
        lat = -1;
        for (k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            if (done8) begin
                lat = k;
                break;
            end
        end
        chk("w8 b2b latency", 64'(lat), 64'd8);
        chk("w8 b2b lo", 64'(lo8), 64'h0F);
        chk("w8 b2b hi", 64'(hi8), 64'h00);

        // Asynchronous reset during the 5th cycle of a DIV.
        @(negedge clk);
        start32 = 1'b1; op32 = 2'd2; a32 = 32'hFFFFFF9C; b32 = 32'd3;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (5) @(posedge clk);
        #2 clrn = 1'b0;
        #1;
        chk("async reset busy", 64'(busy32), 64'd0);
        chk("async reset done", 64'(done32), 64'd0);
        chk("async reset hi",   64'(hi32),   64'd0);
        chk("async reset lo",   64'(lo32),   64'd0);
        chk("async reset dz",   64'(dz32),   64'd0);
        chk("async reset lo8",  64'(lo8),    64'd0);
        @(negedge clk);
        clrn = 1'b1;
        doOp32(2'd2, 32'hFFFFFF9C, 32'd3, rh, rl, rdz, lat, bc);
        chk("post reset latency", 64'(lat), 64'd32);
        chk("post reset lo", 64'(rl), 64'hFFFFFFDF);
        chk("post reset hi", 64'(rh), 64'hFFFFFFFF);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 9) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 9))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            refModel(32, ro, 64'(ra), 64'(rb), eh, el, edz);
            doOp32(ro, ra, rb, rh, rl, rdz, lat, bc);
            chk("rnd32 latency", 64'(lat), 64'd32);
            chk("rnd32 hi", 64'(rh), eh);
            chk("rnd32 lo", 64'(rl), el);
            chk("rnd32 div_zero", 64'(rdz), 64'(edz));
        end

        for (int i = 0; i < 60; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = 32'($urandom_range(0, 255));
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(0, 255));
            refModel(8, ro, 64'(ra), 64'(rb), eh, el, edz);
            doOp8(ro, ra[7:0], rb[7:0], rh8, rl8, rdz, lat);
            chk("rnd8 latency", 64'(lat), 64'd8);
            chk("rnd8 hi", 64'(rh8), eh);
            chk("rnd8 lo", 64'(rl8), el);
            chk("rnd8 div_zero", 64'(rdz), 64'(edz));
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/md_iter_unit.md
# md_iter_unit

Parametrised iterative multiply/divide unit producing HI/LO results for the execute stage. One radix-2 datapath performs signed or unsigned multiply or divide over `W` cycles. It sits beside the ALU in EXE and feeds the HI/LO register file. Compared with the fixed 32-bit mult/div, it generalises operand width, adds a pipeline-flush abort, and adds an explicit divide-by-zero flag.

## Interface
Parameters:
- `W`, 32, operand width in bits; must be ≥ 4. `hi` and `lo` are each `W` bits wide.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `clrn`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request a new operation; sampled only in IDLE.
- `op`  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  W  multiplicand or dividend; sampled with `start`.
- `b`  in  W  multiplier or divisor; sampled with `start`.
- `flush`  in  1  synchronous abort from the hazard unit.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; `hi`/`lo` updated this cycle.
- `hi`  out  W  multiply: upper product half; divide: remainder.
- `lo`  out  W  multiply: lower product half; divide: quotient.
- `div_zero`  out  1  last completed divide had `b` = 0; valid with `done`.

## Operation
- States: IDLE and RUN. A W-bit iteration counter `cnt` counts 0..W-1.
- **IDLE, `start`=1, `flush`=0:**
  - latch `op`, |a| and |b|; magnitudes apply only to signed ops, unsigned ops take raw values;
  - record the result signs;
  - clear the accumulator and `cnt`;
  - go to RUN, `busy`=1.
- **RUN, multiply:** shift-add, one multiplier bit per cycle, 2W-bit accumulator.
- **RUN, divide:** restoring division, one quotient bit per cycle, W+1-bit partial remainder.
- **Completion:** on the edge where `cnt`=W-1:
  - apply sign correction;
  - write `hi`/`lo` and set `done`=1;
  - clear `busy` and return to IDLE.
- **Sign rules, signed ops:**
  - product negated when the operand signs differ;
  - quotient negated when the signs differ;
  - remainder takes the sign of the dividend.
  - All arithmetic is modulo 2^W per half.
- **-2^(W-1) / -1 (DIV):** `lo`=-2^(W-1) (wraps), `hi`=0; `div_zero`=0.
- **Divide by zero (DIV or DIVU, `b`=0):** still takes W cycles; then `lo`=all ones, `hi`=`a` as sampled, `div_zero`=1.
- **Multiply completion:** `div_zero`=0.
- **`start` while RUN:** ignored; the operation in flight is not disturbed.
- **`flush`=1 in RUN:** next edge returns to IDLE with `busy`=0 and no `done`; `hi`, `lo` and `div_zero` keep their previous values.
- **`flush` and `start` both high in IDLE:** `flush` wins and `start` is ignored.
- **`hi`/`lo`/`div_zero`:** change only on a `done` edge and hold between operations.

## Timing
- **Reset values:** `busy`=0, `done`=0, `hi`=0, `lo`=0, `div_zero`=0; state IDLE; `cnt`=0.
- **Reset mid-operation:** takes effect immediately (asynchronous); the result is discarded.
- **Start:** `start` sampled at edge E0 → `busy`=1 after E0.
- **Iterations:** edges E1..EW.
  - at EW: `done`=1, `busy`=0, results valid;
  - `done` falls after EW+1.
- **Latency:** W cycles from the sampling edge to `done`; `busy` is high for exactly W cycles.
- **Back-to-back:** `start` high in the `done` cycle is accepted at EW+1 (state is IDLE), giving zero bubble between operations.
- **Flush:** `flush` high at any RUN edge Ek (1≤k≤W) aborts at that edge, including k=W, where `done` is suppressed.
- **Hazard interface:** `busy` and `done` are registered outputs, with no combinational path from inputs; downstream stall logic uses `busy`.

## Test plan
- **MULT, W=32:** `a`=-3, `b`=5 → `busy` high for 32 cycles; `done` at cycle 32 with `hi`=FFFFFFFF, `lo`=FFFFFFF1, `div_zero`=0.
- **DIVU and DIV, W=32:**
  - DIVU 100/7 → `lo`=0000000E, `hi`=00000002;
  - DIV -7/2 → `lo`=FFFFFFFD, `hi`=FFFFFFFF.
- **Divide edge cases, W=32:**
  - DIV 80000000/FFFFFFFF → `lo`=80000000, `hi`=0;
  - DIVU 12345678/0 → `lo`=FFFFFFFF, `hi`=12345678, `div_zero`=1.
- **Flush and ignored start:**
  - start MULTU 6×7, pulse `flush` at E10 → `busy`=0 after E10, no `done`, `hi`/`lo` unchanged;
  - pulse `start` during RUN → ignored.
- **W=8 instance and back-to-back:**
  - MULTU FF×FF → `hi`=FE, `lo`=01 after 8 cycles;
  - a second `start` held in the `done` cycle → second `done` exactly 8 cycles later.
- **Reset mid-operation:** drop `clrn` at cycle 5 of a DIV → all outputs 0 immediately; after release, `start` is accepted normally.
